// File: rtl/ctr_chain_tc.sv
// Two-stage modulo counter chain with terminal-count decode and wrap pulse.
// Define CTR_CHAIN_STRETCH_EN to stretch tc_out to PW clocks (retriggerable).
module ctr_chain_tc #(
  parameter int LO_MOD = 64,
  parameter int HI_MOD = 16,
  parameter int PW     = 4,
  parameter int W_LO   = $clog2(LO_MOD),
  parameter int W_HI   = $clog2(HI_MOD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  output logic [W_LO-1:0] lo,
  output logic [W_HI-1:0] hi,
  output logic            lo_tc,
  output logic            hi_tc,
  output logic            tc_out
);

  localparam logic [W_LO-1:0] LO_MAX = W_LO'(LO_MOD - 1);
  localparam logic [W_HI-1:0] HI_MAX = W_HI'(HI_MOD - 1);

  logic [W_LO-1:0] lo_q, lo_d;
  logic [W_HI-1:0] hi_q, hi_d;
  logic            tc_q;
  logic            fire;

  always_comb begin
    lo_tc = en & (lo_q == LO_MAX);
    hi_tc = lo_tc & (hi_q == HI_MAX);
    fire  = hi_tc & ~clr;
    lo_d  = lo_q;
    hi_d  = hi_q;
    if (clr) begin
      lo_d = '0;
      hi_d = '0;
    end else if (en) begin
      lo_d = lo_tc ? '0 : lo_q + 1'b1;
      if (lo_tc)
        hi_d = (hi_q == HI_MAX) ? '0 : hi_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

`ifdef CTR_CHAIN_STRETCH_EN
  localparam int W_PW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [W_PW-1:0] CNT_LD = W_PW'(PW - 1);

  typedef enum logic { S_IDLE, S_PULSE } st_t;

  st_t             st_q;
  logic [W_PW-1:0] cnt_q;

  // A new wrap in PULSE reloads the count so back-to-back pulses merge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (fire) begin
            st_q  <= S_PULSE;
            cnt_q <= CNT_LD;
            tc_q  <= 1'b1;
          end else begin
            tc_q  <= 1'b0;
          end
        end
        S_PULSE: begin
          if (fire) begin
            cnt_q <= CNT_LD;
            tc_q  <= 1'b1;
          end else if (cnt_q == '0) begin
            st_q  <= S_IDLE;
            tc_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            tc_q  <= 1'b1;
          end
        end
      endcase
    end
  end
`else
  // PW has no effect in the one-clock build.
  localparam bit PW_OK = (PW >= 1);

  always_ff @(posedge clk) begin
    if (!rst_n) tc_q <= 1'b0;
    else        tc_q <= fire & PW_OK;
  end
`endif

  assign lo     = lo_q;
  assign hi     = hi_q;
  assign tc_out = tc_q;

endmodule

// File: tb/tb_ctr_chain_tc.sv
// Scoreboard bench for ctr_chain_tc: a 4x3 chain (PW=2) and a 2x2 chain (PW=5).
// Both instances share stimulus; a reference model predicts every cycle.
module tb_ctr_chain_tc;

`ifdef CTR_CHAIN_STRETCH_EN
  localparam bit STR = 1'b1;
`else
  localparam bit STR = 1'b0;
`endif
  localparam int PWA = STR ? 2 : 1;
  localparam int PWB = STR ? 5 : 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, clr;
  logic [1:0] lo_a, hi_a;
  logic       lo_tc_a, hi_tc_a, tc_out_a;
  logic [0:0] lo_b, hi_b;
  logic       lo_tc_b, hi_tc_b, tc_out_b;

  ctr_chain_tc #(.LO_MOD(4), .HI_MOD(3), .PW(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .lo(lo_a), .hi(hi_a), .lo_tc(lo_tc_a), .hi_tc(hi_tc_a),
    .tc_out(tc_out_a)
  );

  ctr_chain_tc #(.LO_MOD(2), .HI_MOD(2), .PW(5)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .lo(lo_b), .hi(hi_b), .lo_tc(lo_tc_b), .hi_tc(hi_tc_b),
    .tc_out(tc_out_b)
  );

  typedef struct {
    int lo;
    int hi;
    int rem;
    int tc;
  } mst_t;

  typedef struct {
    int lo_a;
    int hi_a;
    int tc_a;
    int lo_b;
    int hi_b;
    int tc_b;
  } exp_t;

  exp_t q[$];
  mst_t ma, mb;
  bit   mv = 1'b0;
  int   ntests = 0;
  int   nfail = 0;
  int   nlo_a, nhi_a, ntc_a, nrise_a, ntc_b;
  bit   prev_tc_a;

  function automatic mst_t nxt(mst_t s, bit r, bit e, bit c,
                               int lm, int hm, int pw);
    mst_t n;
    bit   lt, ht, f;
    n  = s;
    lt = e && (s.lo == lm - 1);
    ht = lt && (s.hi == hm - 1);
    f  = ht && !c;
    if (!r) begin
      n = '{0, 0, 0, 0};
      return n;
    end
    if (c) begin
      n.lo = 0;
      n.hi = 0;
    end else if (e) begin
      n.lo = (s.lo + 1) % lm;
      if (lt) n.hi = (s.hi + 1) % hm;
    end
    if (f) begin
      n.tc  = 1;
      n.rem = pw - 1;
    end else if (s.rem > 0) begin
      n.tc  = 1;
      n.rem = s.rem - 1;
    end else begin
      n.tc  = 0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c);
    mst_t na, nb;
    exp_t ex;
    rst_n = r;
    en    = e;
    clr   = c;
    #1;
    if (mv) begin
      chk("lo_tc_a", lo_tc_a, e && ma.lo == 3);
      chk("hi_tc_a", hi_tc_a, e && ma.lo == 3 && ma.hi == 2);
      chk("lo_tc_b", lo_tc_b, e && mb.lo == 1);
      chk("hi_tc_b", hi_tc_b, e && mb.lo == 1 && mb.hi == 1);
    end
    if (lo_tc_a === 1'b1) nlo_a++;
    if (hi_tc_a === 1'b1) nhi_a++;
    na = nxt(ma, r, e, c, 4, 3, PWA);
    nb = nxt(mb, r, e, c, 2, 2, PWB);
    q.push_back('{na.lo, na.hi, na.tc, nb.lo, nb.hi, nb.tc});
    ma = na;
    mb = nb;
    mv = 1'b1;
    @(posedge clk);
    #1;
    ex = q.pop_front();
    chk("lo_a", lo_a, ex.lo_a);
    chk("hi_a", hi_a, ex.hi_a);
    chk("tc_out_a", tc_out_a, ex.tc_a);
    chk("lo_b", lo_b, ex.lo_b);
    chk("hi_b", hi_b, ex.hi_b);
    chk("tc_out_b", tc_out_b, ex.tc_b);
    if (tc_out_a === 1'b1) ntc_a++;
    if (tc_out_a === 1'b1 && !prev_tc_a) nrise_a++;
    prev_tc_a = (tc_out_a === 1'b1);
    if (tc_out_b === 1'b1) ntc_b++;
  endtask

  task automatic clr_cnt();
    nlo_a   = 0;
    nhi_a   = 0;
    ntc_a   = 0;
    nrise_a = 0;
    ntc_b   = 0;
  endtask

  initial begin
    prev_tc_a = 1'b0;
    clr_cnt();

    // reset with en high
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_lo", lo_a, 0);
    chk("rst_tc", tc_out_a, 0);

    // full chain wrap, pulse width
    clr_cnt();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
    chk("wrap_tc13", tc_out_a, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("wrap_lo_tc_n", nlo_a, 3);
    chk("wrap_hi_tc_n", nhi_a, 1);
    chk("wrap_pw", ntc_a, PWA);

    // gated enable: 12 advances over 24 clocks
    clr_cnt();
    for (int i = 0; i < 24; i++) step(1'b1, (i % 2) == 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk("gate_hi_tc_n", nhi_a, 1);
    chk("gate_pulses", nrise_a, 1);
    chk("gate_lo_end", lo_a, 0);

    // clr coinciding with hi_tc suppresses the pulse
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0);
    chk("pre_clr_lo", lo_a, 3);
    chk("pre_clr_hi", hi_a, 2);
    clr_cnt();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("clr_no_pulse", ntc_a, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("clr_idle_lo", lo_a, 0);
    chk("clr_idle_hi", hi_a, 0);

    // small chain: retrigger keeps tc_out high, reset cuts it
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    clr_cnt();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    chk("retrig_high_n", ntc_b, STR ? 8 : 2);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_mid_pulse", tc_out_b, 0);
    chk("sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
